// File: rtl/phy_ready_table.sv
// Physical-register ready table: rename allocation clears a bit, writeback wakes it,
// flush marks everything ready. Drives Wake_List/Ready_Count for EX issue.
package phy_ready_table_pkg;
  typedef struct packed {
    logic Clk;
    logic Rst;
  } Global;

  typedef struct packed {
    logic Flush;
    logic Stall;
  } Local;
endpackage

module phy_ready_table
  import phy_ready_table_pkg::*;
#(
  parameter int unsigned Ports      = 4,
  parameter int unsigned Wake_Delay = 0
) (
  input  Global               System,
  input  Local                Cntl,
  input  logic                Alloc0_En,
  input  logic [5:0]          Alloc0_Dst,
  input  logic                Alloc1_En,
  input  logic [5:0]          Alloc1_Dst,
  input  logic [Ports-1:0]    WB_We,
  input  logic [Ports*6-1:0]  WB_Dst,
  output logic [0:63]         Wake_List,
  output logic [6:0]          Ready_Count,
  output logic                Error,
  output logic [5:0]          Error_Dst
);

  logic [0:63]      ready_q;
  logic [0:63]      ready_d;
  logic [0:63]      alloc_mask;
  logic [0:63]      wake_mask;
  logic             alloc0;
  logic             alloc1;
  logic [Ports-1:0] wake_v;
  logic [5:0]       wake_d [Ports];
  logic             err_hit;
  logic [5:0]       err_dst;
  logic [6:0]       count_d;

  // Register 0 is hard-wired ready, so allocations to it are dropped here.
  assign alloc0 = Alloc0_En & ~Cntl.Stall & (Alloc0_Dst != '0);
  assign alloc1 = Alloc1_En & ~Cntl.Stall & (Alloc1_Dst != '0);

  always_comb begin
    alloc_mask = '0;
    if (alloc0) alloc_mask[Alloc0_Dst] = 1'b1;
    if (alloc1) alloc_mask[Alloc1_Dst] = 1'b1;
  end

  generate
    if (Wake_Delay == 0) begin : g_direct
      always_comb begin
        wake_v = WB_We;
        for (int unsigned p = 0; p < Ports; p++) wake_d[p] = WB_Dst[p*6 +: 6];
      end
    end else begin : g_line
      logic [Ports-1:0] line_v [Wake_Delay];
      logic [5:0]       line_d [Wake_Delay][Ports];

      // Entries still travelling are killed by a re-allocation of their index;
      // the exiting stage is left alone so a collision there is reported as an error.
      always_ff @(posedge System.Clk) begin
        if (System.Rst || Cntl.Flush) begin
          for (int unsigned s = 0; s < Wake_Delay; s++) line_v[s] <= '0;
        end else begin
          line_v[0] <= WB_We;
          for (int unsigned s = 1; s < Wake_Delay; s++)
            for (int unsigned p = 0; p < Ports; p++)
              line_v[s][p] <= line_v[s-1][p] & ~alloc_mask[line_d[s-1][p]];
        end
        for (int unsigned p = 0; p < Ports; p++) line_d[0][p] <= WB_Dst[p*6 +: 6];
        for (int unsigned s = 1; s < Wake_Delay; s++) line_d[s] <= line_d[s-1];
      end

      always_comb begin
        wake_v = line_v[Wake_Delay-1];
        for (int unsigned p = 0; p < Ports; p++) wake_d[p] = line_d[Wake_Delay-1][p];
      end
    end
  endgenerate

  always_comb begin
    wake_mask = '0;
    err_hit   = 1'b0;
    err_dst   = '0;
    for (int unsigned p = 0; p < Ports; p++) begin
      if (wake_v[p] && wake_d[p] != '0) begin
        wake_mask[wake_d[p]] = 1'b1;
        if (!err_hit && (ready_q[wake_d[p]] || alloc_mask[wake_d[p]])) begin
          err_hit = 1'b1;
          err_dst = wake_d[p];
        end
      end
      for (int unsigned q = 0; q < Ports; q++) begin
        if (!err_hit && q != p && WB_We[p] && WB_We[q] &&
            WB_Dst[p*6 +: 6] == WB_Dst[q*6 +: 6] && WB_Dst[p*6 +: 6] != '0) begin
          err_hit = 1'b1;
          err_dst = WB_Dst[p*6 +: 6];
        end
      end
    end
    if (!err_hit && alloc0 && alloc1 && Alloc0_Dst == Alloc1_Dst) begin
      err_hit = 1'b1;
      err_dst = Alloc0_Dst;
    end
  end

  always_comb begin
    if (System.Rst || Cntl.Flush) begin
      ready_d = '1;
    end else begin
      ready_d    = (ready_q | wake_mask) & ~alloc_mask;
      ready_d[0] = 1'b1;
    end
    count_d = '0;
    for (int unsigned i = 0; i < 64; i++) count_d = count_d + 7'(ready_d[i]);
  end

  always_ff @(posedge System.Clk) begin
    ready_q     <= ready_d;
    Ready_Count <= count_d;
    if (System.Rst) begin
      Error     <= 1'b0;
      Error_Dst <= '0;
    end else if (!Cntl.Flush && !Error && err_hit) begin
      Error     <= 1'b1;
      Error_Dst <= err_dst;
    end
  end

  assign Wake_List = ready_q;

endmodule

// File: tb/tb_phy_ready_table.sv
// Directed bench for phy_ready_table: vector table on a zero-delay instance,
// hand-written sequences for the two-cycle delay-line instance.
module tb_phy_ready_table;
  import phy_ready_table_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, stall;
  logic a0, a1;
  logic [5:0] d0, d1;
  logic [3:0] we;
  logic [5:0] w0, w1, w2, w3;
  Global sys;
  Local  cntl;

  logic [0:63] wl0, wl2;
  logic [6:0]  cnt0, cnt2;
  logic        err0, err2;
  logic [5:0]  ed0, ed2;

  int n_cmp = 0;
  int n_bad = 0;

  assign sys.Clk    = clk;
  assign sys.Rst    = rst;
  assign cntl.Flush = flush;
  assign cntl.Stall = stall;

  always #5 clk = ~clk;

  phy_ready_table #(.Ports(4), .Wake_Delay(0)) u0 (
    .System(sys), .Cntl(cntl),
    .Alloc0_En(a0), .Alloc0_Dst(d0), .Alloc1_En(a1), .Alloc1_Dst(d1),
    .WB_We(we), .WB_Dst({w3, w2, w1, w0}),
    .Wake_List(wl0), .Ready_Count(cnt0), .Error(err0), .Error_Dst(ed0)
  );

  phy_ready_table #(.Ports(4), .Wake_Delay(2)) u2 (
    .System(sys), .Cntl(cntl),
    .Alloc0_En(a0), .Alloc0_Dst(d0), .Alloc1_En(a1), .Alloc1_Dst(d1),
    .WB_We(we), .WB_Dst({w3, w2, w1, w0}),
    .Wake_List(wl2), .Ready_Count(cnt2), .Error(err2), .Error_Dst(ed2)
  );

  typedef struct {
    logic       rst, flush, stall;
    logic       a0;
    logic [5:0] d0;
    logic       a1;
    logic [5:0] d1;
    logic [3:0] we;
    logic [5:0] w0, w1, w2, w3;
    logic [5:0] cbit;
    logic       cval;
    logic [6:0] cnt;
    logic       err;
    logic [5:0] edst;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; flush = 0; stall = 0;
    a0 = 0; d0 = 0; a1 = 0; d1 = 0;
    we = 0; w0 = 0; w1 = 0; w2 = 0; w3 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    //          rst fl st  a0 d0  a1 d1  we       w0 w1 w2 w3  bit val cnt err edst
    vecs.push_back('{1, 0, 0, 0, 0,  0, 0,  4'b0000, 0, 0, 0, 0,  0, 1, 64, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0,  0, 0,  4'b0000, 0, 0, 0, 0, 63, 1, 64, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 5,  1, 9,  4'b0000, 0, 0, 0, 0,  5, 0, 62, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  4'b0000, 0, 0, 0, 0,  9, 0, 62, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 12, 0, 0,  4'b0000, 0, 0, 0, 0, 12, 0, 61, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  4'b0000, 0, 0, 0, 0, 12, 0, 61, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  4'b0000, 0, 0, 0, 0, 12, 0, 61, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  4'b0010, 0, 12, 0, 0, 12, 1, 62, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  4'b0101, 5, 0, 9, 0,  9, 1, 64, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 7,  0, 0,  4'b0000, 0, 0, 0, 0,  7, 1, 64, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0,  0, 0,  4'b0000, 0, 0, 0, 0,  0, 1, 64, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  4'b1000, 0, 0, 0, 0,  0, 1, 64, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 30, 1, 31, 4'b0000, 0, 0, 0, 0, 31, 0, 62, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 40, 0, 0,  4'b0000, 0, 0, 0, 0, 40, 0, 61, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0,  0, 0,  4'b0001, 30, 0, 0, 0, 30, 1, 64, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 33, 0, 0,  4'b0000, 0, 0, 0, 0, 33, 0, 63, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  4'b0101, 33, 0, 33, 0, 33, 1, 64, 1, 33});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  4'b0010, 0, 44, 0, 0, 44, 1, 64, 1, 33});
    vecs.push_back('{0, 1, 0, 1, 50, 0, 0,  4'b0000, 0, 0, 0, 0, 50, 1, 64, 1, 33});
    vecs.push_back('{1, 0, 0, 0, 0,  0, 0,  4'b0000, 0, 0, 0, 0,  0, 1, 64, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 63, 1, 63, 4'b0000, 0, 0, 0, 0, 63, 0, 63, 1, 63});
    vecs.push_back('{1, 0, 0, 0, 0,  0, 0,  4'b0000, 0, 0, 0, 0, 63, 1, 64, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 62, 0, 0,  4'b0000, 0, 0, 0, 0, 62, 0, 63, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,  1, 62, 4'b0001, 62, 0, 0, 0, 62, 0, 63, 1, 62});
    vecs.push_back('{1, 0, 0, 0, 0,  0, 0,  4'b0000, 0, 0, 0, 0,  0, 1, 64, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0,  4'b1010, 0, 3, 0, 2,  3, 1, 64, 1, 3});
    vecs.push_back('{1, 0, 0, 0, 0,  0, 0,  4'b0000, 0, 0, 0, 0,  0, 1, 64, 0, 0});

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst; flush = vecs[i].flush; stall = vecs[i].stall;
      a0 = vecs[i].a0; d0 = vecs[i].d0; a1 = vecs[i].a1; d1 = vecs[i].d1;
      we = vecs[i].we; w0 = vecs[i].w0; w1 = vecs[i].w1; w2 = vecs[i].w2; w3 = vecs[i].w3;
      tick();
      check($sformatf("v%0d bit%0d", i, vecs[i].cbit), int'(wl0[vecs[i].cbit]), int'(vecs[i].cval));
      check($sformatf("v%0d bit0", i), int'(wl0[0]), 1);
      check($sformatf("v%0d count", i), int'(cnt0), int'(vecs[i].cnt));
      check($sformatf("v%0d error", i), int'(err0), int'(vecs[i].err));
      check($sformatf("v%0d error_dst", i), int'(ed0), int'(vecs[i].edst));
    end

    // Delayed wake: writeback at edge t becomes visible from t+3.
    idle(); a0 = 1; d0 = 20; tick();
    check("d2 alloc20", int'(wl2[20]), 0);
    idle(); we = 4'b0001; w0 = 20; tick();
    check("d2 wake t+1", int'(wl2[20]), 0);
    idle(); tick();
    check("d2 wake t+2", int'(wl2[20]), 0);
    tick();
    check("d2 wake t+3", int'(wl2[20]), 1);
    check("d2 wake count", int'(cnt2), 64);
    check("d2 wake error", int'(err2), 0);

    // Reallocation cancels the in-flight wake without an error.
    idle(); a0 = 1; d0 = 20; tick();
    idle(); we = 4'b0001; w0 = 20; tick();
    idle(); a0 = 1; d0 = 20; tick();
    idle(); tick();
    check("d2 cancel t+2", int'(wl2[20]), 0);
    tick();
    check("d2 cancel t+3", int'(wl2[20]), 0);
    check("d2 cancel count", int'(cnt2), 63);
    check("d2 cancel error", int'(err2), 0);

    // Waking an already-ready register is flagged when the entry leaves the line.
    idle(); we = 4'b0010; w1 = 25; tick();
    idle(); tick();
    check("d2 late err t+1", int'(err2), 0);
    tick();
    check("d2 late err t+2", int'(err2), 1);
    check("d2 late err dst", int'(ed2), 25);

    // Flush must drop the in-flight entry, so a later allocation sees no collision.
    idle(); rst = 1; tick();
    check("d2 reset error", int'(err2), 0);
    check("d2 reset dst", int'(ed2), 0);
    idle(); a0 = 1; d0 = 20; tick();
    idle(); we = 4'b0001; w0 = 20; tick();
    idle(); flush = 1; tick();
    check("d2 flush count", int'(cnt2), 64);
    idle(); a0 = 1; d0 = 20; tick();
    check("d2 post-flush bit20", int'(wl2[20]), 0);
    check("d2 post-flush error", int'(err2), 0);
    idle(); tick();
    check("d2 post-flush count", int'(cnt2), 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
